// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared constants and types for the vector decode stage and its register
// file. It holds the default geometry (element width, lane count, register
// count, instruction width), the immediate-mode encoding, and the bit
// positions of every field inside the instruction word.
// ---------------------------------------------------------------------------
package vec_pkg;

    localparam int N     = 20;
    localparam int LANES = 8;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);
    localparam int IW    = 28;

    typedef logic [LANES-1:0][N-1:0] vec_t;

    typedef enum logic [1:0] {
        IMM_ZX   = 2'b00,
        IMM_SX   = 2'b01,
        IMM_HI   = 2'b10,
        IMM_RAMP = 2'b11
    } imm_src_e;

    // Instruction field positions (each register field is AW bits wide)
    localparam int RN_LSB       = 0;
    localparam int RM_ALT_LSB   = 4;
    localparam int RM_LSB       = 8;
    localparam int RD_LSB       = 12;
    localparam int IMM_LSB      = 18;
    localparam int IMM_W        = 10;
    localparam int IMM_HI_SHIFT = 10;

endpackage

// File: rtl/vec_regfile_bypass.sv
// ---------------------------------------------------------------------------
// vec_regfile_bypass
// Vector register file: NREGS entries of W bits, one synchronous write port
// and two asynchronous read ports. A read of the address being written in
// the same cycle returns the incoming write data (write-first bypass), so
// the decode stage never sees a stale value for a register retiring now.
// Ports:
//   clk      in   clock, rising edge
//   RST      in   asynchronous active-low reset, clears every entry
//   i_we     in   write enable
//   i_wa     in   write address
//   i_wd     in   write data
//   i_ra1    in   read address, port 1
//   i_ra2    in   read address, port 2
//   o_rd1    out  read data, port 1 (bypassed)
//   o_rd2    out  read data, port 2 (bypassed)
// ---------------------------------------------------------------------------
module vec_regfile_bypass #(
    parameter int W     = 160,
    parameter int NREGS = 16
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       i_we,
    input  logic [$clog2(NREGS)-1:0]   i_wa,
    input  logic [W-1:0]               i_wd,
    input  logic [$clog2(NREGS)-1:0]   i_ra1,
    input  logic [$clog2(NREGS)-1:0]   i_ra2,
    output logic [W-1:0]               o_rd1,
    output logic [W-1:0]               o_rd2
);

    logic [W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NREGS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Write-first: a same-cycle write to the read address wins over storage
    assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/vec_decode_stage.sv
// ---------------------------------------------------------------------------
// vec_decode_stage
// Vector decode stage between fetch and vector execute. Selects source
// register addresses, reads both operand vectors, extends the immediate to
// every lane, stalls on read-after-write hazards tracked by a pending-write
// scoreboard, and registers everything into the D/E pipeline boundary with
// a valid/ready handshake on both sides. Owns the vector register file.
// Ports:
//   clk        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   in_valid   in   fetch presents Instr
//   in_ready   out  decode accepts Instr this cycle
//   Instr      in   instruction word (rn, rm_alt, rm, rd, imm10)
//   RegSrc     in   [0]: ra1 = last register, [1]: ra2 = rm_alt
//   ImmSrc     in   immediate mode (zext / sext / high / lane ramp)
//   RegWriteD  in   accepted instruction will write rd
//   RegWriteW  in   writeback enable
//   wa3w       in   writeback address
//   wd3        in   writeback data
//   flushE     in   kill D/E contents
//   out_valid  out  D/E register holds a valid instruction
//   out_ready  in   execute accepts D/E contents
//   rd1E,rd2E  out  registered operand vectors
//   ExtImmE    out  registered extended immediate
//   ra1E,ra2E  out  registered source addresses
//   wa3E       out  registered destination address
//   RegWriteE  out  registered RegWriteD
// ---------------------------------------------------------------------------
module vec_decode_stage
    import vec_pkg::*;
#(
    parameter int N     = vec_pkg::N,
    parameter int LANES = vec_pkg::LANES,
    parameter int NREGS = vec_pkg::NREGS,
    parameter int IW    = vec_pkg::IW
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IW-1:0]               Instr,
    input  logic [1:0]                  RegSrc,
    input  logic [1:0]                  ImmSrc,
    input  logic                        RegWriteD,
    input  logic                        RegWriteW,
    input  logic [$clog2(NREGS)-1:0]    wa3w,
    input  logic [LANES*N-1:0]          wd3,
    input  logic                        flushE,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*N-1:0]          rd1E,
    output logic [LANES*N-1:0]          rd2E,
    output logic [LANES*N-1:0]          ExtImmE,
    output logic [$clog2(NREGS)-1:0]    ra1E,
    output logic [$clog2(NREGS)-1:0]    ra2E,
    output logic [$clog2(NREGS)-1:0]    wa3E,
    output logic                        RegWriteE
);

    localparam int RAW = $clog2(NREGS);
    localparam int VW  = LANES * N;

    logic [RAW-1:0]   w_ra1;
    logic [RAW-1:0]   w_ra2;
    logic [RAW-1:0]   w_rd;
    logic [IMM_W-1:0] w_imm10;
    logic [VW-1:0]    w_rd1;
    logic [VW-1:0]    w_rd2;
    logic [VW-1:0]    w_extImm;
    logic             w_src1Hazard;
    logic             w_src2Hazard;
    logic             w_hazard;
    logic             w_acc;
    logic [NREGS-1:0] w_pendNext;
    logic             w_unusedBits;

    logic [NREGS-1:0] r_pend;
    logic             r_outValid;
    logic [VW-1:0]    r_rd1E;
    logic [VW-1:0]    r_rd2E;
    logic [VW-1:0]    r_extImmE;
    logic [RAW-1:0]   r_ra1E;
    logic [RAW-1:0]   r_ra2E;
    logic [RAW-1:0]   r_wa3E;
    logic             r_regWriteE;

    // Field extraction and source-address selection
    assign w_ra1   = RegSrc[0] ? RAW'(NREGS - 1) : Instr[RN_LSB +: RAW];
    assign w_ra2   = RegSrc[1] ? Instr[RM_ALT_LSB +: RAW] : Instr[RM_LSB +: RAW];
    assign w_rd    = Instr[RD_LSB +: RAW];
    assign w_imm10 = Instr[IMM_LSB +: IMM_W];

    // Instruction bits between rd and imm10 carry no meaning here
    assign w_unusedBits = ^Instr[IMM_LSB-1:RD_LSB+RAW];

    vec_regfile_bypass #(
        .W     (VW),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .RST   (RST),
        .i_we  (RegWriteW),
        .i_wa  (wa3w),
        .i_wd  (wd3),
        .i_ra1 (w_ra1),
        .i_ra2 (w_ra2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // A pending source that is being written back right now is served by the
    // register-file bypass, so it does not stall. Only a presented instruction
    // can cause a hazard; destination-only overlap never stalls.
    assign w_src1Hazard = r_pend[w_ra1] & ~(RegWriteW & (wa3w == w_ra1));
    assign w_src2Hazard = r_pend[w_ra2] & ~(RegWriteW & (wa3w == w_ra2));
    assign w_hazard     = in_valid & (w_src1Hazard | w_src2Hazard);

    // A flush cycle accepts nothing, which keeps the flush/accept ordering simple
    assign in_ready = (~r_outValid | out_ready) & ~w_hazard & ~flushE;
    assign w_acc    = in_valid & in_ready;

    // Scoreboard update: writeback and flush clear, acceptance sets last so a
    // set and clear of the same register in one cycle leaves it pending.
    always_comb begin
        w_pendNext = r_pend;
        if (RegWriteW) begin
            w_pendNext[wa3w] = 1'b0;
        end
        if (flushE && r_outValid && r_regWriteE) begin
            w_pendNext[r_wa3E] = 1'b0;
        end
        if (w_acc && RegWriteD) begin
            w_pendNext[w_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    // Immediate extension, replicated per lane; the ramp mode adds the lane index
    always_comb begin
        w_extImm = '0;
        for (int i = 0; i < LANES; i++) begin
            case (imm_src_e'(ImmSrc))
                IMM_ZX:   w_extImm[i*N +: N] = N'(w_imm10);
                IMM_SX:   w_extImm[i*N +: N] = {{(N-IMM_W){w_imm10[IMM_W-1]}}, w_imm10};
                IMM_HI:   w_extImm[i*N +: N] = N'(w_imm10) << IMM_HI_SHIFT;
                IMM_RAMP: w_extImm[i*N +: N] = N'(w_imm10) + N'(i);
                default:  w_extImm[i*N +: N] = '0;
            endcase
        end
    end

    // D/E boundary: flush kills, a stalled consumer holds everything, an
    // accept loads, and a consumer draining with nothing new clears valid.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_outValid  <= 1'b0;
            r_rd1E      <= '0;
            r_rd2E      <= '0;
            r_extImmE   <= '0;
            r_ra1E      <= '0;
            r_ra2E      <= '0;
            r_wa3E      <= '0;
            r_regWriteE <= 1'b0;
        end else if (flushE) begin
            r_outValid  <= 1'b0;
            r_regWriteE <= 1'b0;
        end else if (w_acc) begin
            r_outValid  <= 1'b1;
            r_rd1E      <= w_rd1;
            r_rd2E      <= w_rd2;
            r_extImmE   <= w_extImm;
            r_ra1E      <= w_ra1;
            r_ra2E      <= w_ra2;
            r_wa3E      <= w_rd;
            r_regWriteE <= RegWriteD;
        end else if (out_ready) begin
            r_outValid  <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign rd1E      = r_rd1E;
    assign rd2E      = r_rd2E;
    assign ExtImmE   = r_extImmE;
    assign ra1E      = r_ra1E;
    assign ra2E      = r_ra2E;
    assign wa3E      = r_wa3E;
    assign RegWriteE = r_regWriteE;

endmodule

// File: tb/tb_vec_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_vec_decode_stage
// Self-checking bench for vec_decode_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model of
// the register file, scoreboard and D/E boundary.
// ---------------------------------------------------------------------------
module tb_vec_decode_stage;
    import vec_pkg::*;

    localparam int W = LANES * N;

    logic              clk;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     Instr;
    logic [1:0]        RegSrc;
    logic [1:0]        ImmSrc;
    logic              RegWriteD;
    logic              RegWriteW;
    logic [AW-1:0]     wa3w;
    logic [W-1:0]      wd3;
    logic              flushE;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      rd1E;
    logic [W-1:0]      rd2E;
    logic [W-1:0]      ExtImmE;
    logic [AW-1:0]     ra1E;
    logic [AW-1:0]     ra2E;
    logic [AW-1:0]     wa3E;
    logic              RegWriteE;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    logic [W-1:0]  mRegs [NREGS];
    bit            mPend [NREGS];
    bit            mValid;
    logic [W-1:0]  mRd1;
    logic [W-1:0]  mRd2;
    logic [W-1:0]  mImm;
    logic [AW-1:0] mRa1;
    logic [AW-1:0] mRa2;
    logic [AW-1:0] mWa3;
    bit            mRw;

    vec_decode_stage dut (
        .clk       (clk),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr     (Instr),
        .RegSrc    (RegSrc),
        .ImmSrc    (ImmSrc),
        .RegWriteD (RegWriteD),
        .RegWriteW (RegWriteW),
        .wa3w      (wa3w),
        .wd3       (wd3),
        .flushE    (flushE),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd1E      (rd1E),
        .rd2E      (rd2E),
        .ExtImmE   (ExtImmE),
        .ra1E      (ra1E),
        .ra2E      (ra2E),
        .wa3E      (wa3E),
        .RegWriteE (RegWriteE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [IW-1:0] ins, input logic [1:0] rs,
                                 input logic [1:0] is, input bit rwd, input bit rww,
                                 input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                 input bit fl, input bit ordy);
        in_valid  = iv;
        Instr     = ins;
        RegSrc    = rs;
        ImmSrc    = is;
        RegWriteD = rwd;
        RegWriteW = rww;
        wa3w      = wa;
        wd3       = wd;
        flushE    = fl;
        out_ready = ordy;
    endtask

    function automatic logic [IW-1:0] mkInstr(input int rn, input int rmAlt, input int rm,
                                              input int rd, input int imm);
        logic [IW-1:0] x;
        x        = '0;
        x[3:0]   = 4'(rn);
        x[7:4]   = 4'(rmAlt);
        x[11:8]  = 4'(rm);
        x[15:12] = 4'(rd);
        x[27:18] = 10'(imm);
        return x;
    endfunction

    // Immediate value per lane, from plain integer arithmetic
    function automatic logic [W-1:0] refImm(input logic [1:0] mode, input int imm);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int lane = 0; lane < LANES; lane++) begin
            case (mode)
                2'd0:    v = imm;
                2'd1:    v = (imm >= 512) ? (imm - 1024 + (1 << N)) : imm;
                2'd2:    v = imm * 1024;
                default: v = (imm + lane) % (1 << N);
            endcase
            r[lane*N +: N] = v[N-1:0];
        end
        return r;
    endfunction

    task automatic resetModel();
        for (int k = 0; k < NREGS; k++) begin
            mRegs[k] = '0;
            mPend[k] = 1'b0;
        end
        mValid = 1'b0;
        mRd1 = '0; mRd2 = '0; mImm = '0;
        mRa1 = '0; mRa2 = '0; mWa3 = '0;
        mRw  = 1'b0;
    endtask

    // One clock: check in_ready before the edge, advance the model at the
    // edge, then compare the registered outputs on the falling edge.
    task automatic stepCycle();
        bit            haz;
        bit            expReady;
        bit            acc;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [W-1:0]  v1;
        logic [W-1:0]  v2;
        #1;
        a1  = RegSrc[0] ? AW'(NREGS - 1) : Instr[3:0];
        a2  = RegSrc[1] ? Instr[7:4] : Instr[11:8];
        haz = (mPend[a1] && !(RegWriteW && wa3w == a1)) ||
              (mPend[a2] && !(RegWriteW && wa3w == a2));
        expReady = !(mValid && !out_ready) && !haz && !flushE;
        if (in_valid) checkOutput("in_ready", W'(in_ready), W'(expReady));
        acc = in_valid && expReady;
        v1  = (RegWriteW && wa3w == a1) ? wd3 : mRegs[a1];
        v2  = (RegWriteW && wa3w == a2) ? wd3 : mRegs[a2];
        @(posedge clk);
        if (!RST) begin
            resetModel();
        end else begin
            if (RegWriteW) mPend[wa3w] = 1'b0;
            if (flushE && mValid && mRw) mPend[mWa3] = 1'b0;
            if (acc && RegWriteD) mPend[Instr[15:12]] = 1'b1;
            if (flushE) begin
                mValid = 1'b0;
            end else if (acc) begin
                mValid = 1'b1;
                mRd1 = v1;
                mRd2 = v2;
                mImm = refImm(ImmSrc, int'(Instr[27:18]));
                mRa1 = a1;
                mRa2 = a2;
                mWa3 = Instr[15:12];
                mRw  = RegWriteD;
            end else if (out_ready) begin
                mValid = 1'b0;
            end
            if (RegWriteW) mRegs[wa3w] = wd3;
        end
        @(negedge clk);
        checkOutput("out_valid", W'(out_valid), W'(mValid));
        if (mValid) begin
            checkOutput("rd1E", rd1E, mRd1);
            checkOutput("rd2E", rd2E, mRd2);
            checkOutput("ExtImmE", ExtImmE, mImm);
            checkOutput("ra1E", W'(ra1E), W'(mRa1));
            checkOutput("ra2E", W'(ra2E), W'(mRa2));
            checkOutput("wa3E", W'(wa3E), W'(mWa3));
            checkOutput("RegWriteE", W'(RegWriteE), W'(mRw));
        end
    endtask

    initial begin
        logic [W-1:0] vec;
        logic [W-1:0] expVec;
        logic [N-1:0] laneExp [4];

        RST = 1'b0;
        applyStimulus(1'b1, mkInstr(0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset out_valid", W'(out_valid), '0);
        checkOutput("reset rd1E", rd1E, '0);
        checkOutput("reset ExtImmE", ExtImmE, '0);
        checkOutput("reset wa3E", W'(wa3E), '0);
        checkOutput("reset RegWriteE", W'(RegWriteE), '0);
        checkOutput("reset in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        RST = 1'b1;
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

        // Writeback r3 then read it through port 1
        for (int i = 0; i < LANES; i++) vec[i*N +: N] = N'(32'h100 + i);
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b1, AW'(3), vec, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, mkInstr(3, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("T1 out_valid", W'(out_valid), W'(1));
        for (int i = 0; i < LANES; i++)
            checkOutput("T1 rd1E lane", W'(rd1E[i*N +: N]), W'(32'h100 + i));
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();

        // Immediate sweep with imm10 = 0x3FF
        laneExp[0] = 20'h003FF;
        laneExp[1] = 20'hFFFFF;
        laneExp[2] = 20'hFFC00;
        laneExp[3] = 20'h003FF;
        for (int m = 0; m < 4; m++) begin
            applyStimulus(1'b1, mkInstr(0, 0, 0, 0, 10'h3FF), 2'b00, 2'(m), 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            stepCycle();
            for (int i = 0; i < LANES; i++)
                expVec[i*N +: N] = (m == 3) ? laneExp[3] + N'(i) : laneExp[m];
            checkOutput("T2 ExtImmE", ExtImmE, expVec);
        end
        checkOutput("T2 ramp lane7", W'(ExtImmE[7*N +: N]), W'(20'h00406));

        // RAW stall on r5 released by its writeback, with bypassed operand
        applyStimulus(1'b1, mkInstr(0, 0, 0, 5, 0), 2'b00, 2'b00, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, mkInstr(5, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        repeat (2) begin
            #1;
            checkOutput("T3 stall in_ready", W'(in_ready), W'(0));
            stepCycle();
        end
        for (int i = 0; i < LANES; i++) vec[i*N +: N] = N'($urandom);
        applyStimulus(1'b1, mkInstr(5, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b1, AW'(5), vec, 1'b0, 1'b1);
        #1;
        checkOutput("T3 bypass in_ready", W'(in_ready), W'(1));
        stepCycle();
        checkOutput("T3 bypass rd1E", rd1E, vec);

        // Backpressure: hold A for three cycles, then B follows exactly once
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, mkInstr(1, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, mkInstr(2, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) begin
            #1;
            checkOutput("T4 hold in_ready", W'(in_ready), W'(0));
            stepCycle();
            checkOutput("T4 hold ra1E", W'(ra1E), W'(1));
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("T4 release ra1E", W'(ra1E), W'(2));
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("T4 no duplicate", W'(out_valid), W'(0));

        // Flush of a writing instruction releases its scoreboard entry
        applyStimulus(1'b1, mkInstr(0, 0, 0, 7, 0), 2'b00, 2'b00, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("T5 flushed out_valid", W'(out_valid), W'(0));
        applyStimulus(1'b1, mkInstr(7, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #1;
        checkOutput("T5 no stall in_ready", W'(in_ready), W'(1));
        stepCycle();
        checkOutput("T5 ra1E", W'(ra1E), W'(7));

        // Reset while stalled on r2
        applyStimulus(1'b1, mkInstr(0, 0, 0, 2, 0), 2'b00, 2'b00, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b1, mkInstr(2, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #1;
        checkOutput("T6 stall in_ready", W'(in_ready), W'(0));
        stepCycle();
        RST = 1'b0;
        #1;
        checkOutput("T6 async out_valid", W'(out_valid), '0);
        checkOutput("T6 async rd1E", rd1E, '0);
        checkOutput("T6 async ra1E", W'(ra1E), '0);
        checkOutput("T6 async wa3E", W'(wa3E), '0);
        checkOutput("T6 async RegWriteE", W'(RegWriteE), '0);
        resetModel();
        stepCycle();
        RST = 1'b1;
        #1;
        checkOutput("T6 post-reset in_ready", W'(in_ready), W'(1));
        stepCycle();
        checkOutput("T6 post-reset ra1E", W'(ra1E), W'(2));

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < LANES; i++) vec[i*N +: N] = N'($urandom);
            applyStimulus(1'($urandom_range(0, 3) != 0), IW'($urandom), 2'($urandom), 2'($urandom),
                          1'($urandom), 1'($urandom_range(0, 9) < 3), AW'($urandom), vec,
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
